// File: rtl/alu_serial_n.sv
// Bit-serial six-operation ALU: processes WIDTH-bit operands one bit per clock
// through a single carry register, with a start/busy/done handshake.
module alu_serial_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] r2,
    input  logic [WIDTH-1:0] r3,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    count_r;
    logic             carry_r;
    logic             cin_r;
    logic [2:0]       sel_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] out_r;
    logic             c_out_r;
    logic             zero_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic             res_bit_s;
    logic             carry_nxt_s;
    logic             arith_s;
    logic [WIDTH-1:0] res_nxt_s;
    logic             c_final_s;
    logic             ovf_final_s;
    logic             carry_load_s;

    // One-bit full adder: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Per-bit datapath: operands are shifted right so bit 0 is always the current bit.
    always_comb begin
        res_bit_s   = 1'b0;
        carry_nxt_s = carry_r;
        arith_s     = 1'b0;
        case (sel_r)
            OP_MOV: res_bit_s = a_r[0];
            OP_NOT: res_bit_s = ~a_r[0];
            OP_ADD: begin
                {carry_nxt_s, res_bit_s} = full_add(a_r[0], b_r[0], carry_r);
                arith_s = 1'b1;
            end
            OP_SUB: begin
                {carry_nxt_s, res_bit_s} = full_add(a_r[0], ~b_r[0], carry_r);
                arith_s = 1'b1;
            end
            OP_OR:  res_bit_s = a_r[0] | b_r[0];
            OP_AND: res_bit_s = a_r[0] & b_r[0];
            default: res_bit_s = 1'b0;
        endcase

        res_nxt_s = {res_bit_s, res_r[WIDTH-1:1]};

        // Reserved opcodes report no carry; logic ops pass the latched carry-in through.
        if (arith_s) begin
            c_final_s = carry_nxt_s;
        end else if (sel_r[2:1] == 2'b11) begin
            c_final_s = 1'b0;
        end else begin
            c_final_s = cin_r;
        end

        // On the last bit, carry_r is the carry into the MSB.
        ovf_final_s = arith_s & (carry_r ^ carry_nxt_s);

        if (select == OP_ADD) begin
            carry_load_s = c_in;
        end else if (select == OP_SUB) begin
            carry_load_s = ~c_in;
        end else begin
            carry_load_s = 1'b0;
        end
    end

    // Control FSM, operand/result shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= '0;
            carry_r <= 1'b0;
            cin_r   <= 1'b0;
            sel_r   <= 3'b000;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            out_r   <= '0;
            c_out_r <= 1'b0;
            zero_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= r2;
                        b_r     <= r3;
                        sel_r   <= select;
                        cin_r   <= c_in;
                        count_r <= '0;
                        carry_r <= carry_load_s;
                        res_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    a_r     <= {1'b0, a_r[WIDTH-1:1]};
                    b_r     <= {1'b0, b_r[WIDTH-1:1]};
                    res_r   <= res_nxt_s;
                    carry_r <= carry_nxt_s;
                    if (count_r == LAST) begin
                        out_r   <= res_nxt_s;
                        c_out_r <= c_final_s;
                        zero_r  <= (res_nxt_s == {WIDTH{1'b0}});
                        ovf_r   <= ovf_final_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign out   = out_r;
    assign c_out = c_out_r;
    assign zero  = zero_r;
    assign ovf   = ovf_r;

endmodule
